// File: rtl/cycle_timer.sv
// Cycle timer: counts a requested number of clocks with Busy high, then pulses Done.
// Supports abort, zero-length intervals and back-to-back restarts from the DONE cycle.
module cycle_timer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Ncycles,
  output logic             Busy,
  output logic             Done,
  output logic             Pulse_n,
  output logic [WIDTH-1:0] Elapsed,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic             start_ok;

  // Abort outranks Start on the same edge, even where Abort itself does nothing.
  assign start_ok  = (state != COUNT) && Start && !Abort;
  assign dbg_state = state;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      target  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Pulse_n <= 1'b1;
      Elapsed <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            target  <= Ncycles;
            Elapsed <= '0;
            if (Ncycles == '0) begin
              state   <= DONE;
              Busy    <= 1'b0;
              Pulse_n <= 1'b1;
              Done    <= 1'b1;
            end else begin
              state   <= COUNT;
              Busy    <= 1'b1;
              Pulse_n <= 1'b0;
              Done    <= 1'b0;
            end
          end else begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
        COUNT: begin
          if (Abort) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Pulse_n <= 1'b1;
            Done    <= 1'b0;
          end else begin
            Elapsed <= Elapsed + 1'b1;
            // target is nonzero in COUNT, so target-1 cannot underflow and Elapsed never wraps.
            if (Elapsed == target - 1'b1) begin
              state   <= DONE;
              Busy    <= 1'b0;
              Pulse_n <= 1'b1;
              Done    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          Busy    <= 1'b0;
          Pulse_n <= 1'b1;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_timer.sv
// Directed bench for cycle_timer: hand-computed expectations, checked 1ns after each rising edge.
module tb_cycle_timer;

  localparam int W = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] ncycles;
  logic         busy;
  logic         done;
  logic         pulse_n;
  logic [W-1:0] elapsed;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  cycle_timer #(.WIDTH(W)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .Start    (start),
    .Abort    (abort),
    .Ncycles  (ncycles),
    .Busy     (busy),
    .Done     (done),
    .Pulse_n  (pulse_n),
    .Elapsed  (elapsed),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic b, input logic d,
                           input logic [W-1:0] e, input logic [1:0] s);
    check_eq({tag, " busy"},    32'(busy),      32'(b));
    check_eq({tag, " done"},    32'(done),      32'(d));
    check_eq({tag, " pulse_n"}, 32'(pulse_n),   32'(!b));
    check_eq({tag, " elapsed"}, 32'(elapsed),   32'(e));
    check_eq({tag, " state"},   32'(dbg_state), 32'(s));
  endtask

  task automatic start_n(input logic [W-1:0] n);
    start   = 1'b1;
    ncycles = n;
    tick();
    start   = 1'b0;
    ncycles = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ncycles = '0;
    tick(); tick();
    check_all("reset", 1'b0, 1'b0, 8'd0, S_IDLE);
    rst = 1'b0;
    tick();
    check_all("idle", 1'b0, 1'b0, 8'd0, S_IDLE);

    // N=5: busy 5 cycles, elapsed 0..5, done on falling busy
    start_n(8'd5);
    check_all("n5 start", 1'b1, 1'b0, 8'd0, S_COUNT);
    for (int m = 1; m <= 4; m++) begin
      tick();
      check_all("n5 count", 1'b1, 1'b0, W'(m), S_COUNT);
    end
    tick();
    check_all("n5 done", 1'b0, 1'b1, 8'd5, S_DONE);
    tick();
    check_all("n5 idle", 1'b0, 1'b0, 8'd5, S_IDLE);

    // N=0: straight to DONE, busy never rises
    start_n(8'd0);
    check_all("n0 done", 1'b0, 1'b1, 8'd0, S_DONE);
    tick();
    check_all("n0 idle", 1'b0, 1'b0, 8'd0, S_IDLE);

    // N=10 with ignored Start in COUNT, then Abort at elapsed=4
    start_n(8'd10);
    tick(); tick();
    check_all("n10 el2", 1'b1, 1'b0, 8'd2, S_COUNT);
    start_n(8'd3);
    check_all("n10 restart ignored", 1'b1, 1'b0, 8'd3, S_COUNT);
    tick();
    check_all("n10 el4", 1'b1, 1'b0, 8'd4, S_COUNT);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all("abort", 1'b0, 1'b0, 8'd4, S_IDLE);
    tick();
    check_all("abort hold", 1'b0, 1'b0, 8'd4, S_IDLE);

    // Back-to-back: N=3 then N=2 from the DONE cycle
    start_n(8'd3);
    tick(); tick();
    check_all("b2b a el2", 1'b1, 1'b0, 8'd2, S_COUNT);
    tick();
    check_all("b2b a done", 1'b0, 1'b1, 8'd3, S_DONE);
    start_n(8'd2);
    check_all("b2b b start", 1'b1, 1'b0, 8'd0, S_COUNT);
    tick();
    check_all("b2b b el1", 1'b1, 1'b0, 8'd1, S_COUNT);
    tick();
    check_all("b2b b done", 1'b0, 1'b1, 8'd2, S_DONE);
    tick();
    check_all("b2b idle", 1'b0, 1'b0, 8'd2, S_IDLE);

    // Reset mid-count at elapsed=3
    start_n(8'd8);
    tick(); tick(); tick();
    check_all("n8 el3", 1'b1, 1'b0, 8'd3, S_COUNT);
    rst = 1'b1;
    tick();
    check_all("mid reset", 1'b0, 1'b0, 8'd0, S_IDLE);
    start = 1'b1; abort = 1'b1; ncycles = 8'd4;
    tick();
    check_all("reset overrides start", 1'b0, 1'b0, 8'd0, S_IDLE);
    rst = 1'b0;
    tick();
    start = 1'b0; abort = 1'b0; ncycles = '0;
    check_all("start+abort idle", 1'b0, 1'b0, 8'd0, S_IDLE);

    // Abort outranks Start in DONE; Abort alone in DONE does nothing
    start_n(8'd1);
    check_all("n1 start", 1'b1, 1'b0, 8'd0, S_COUNT);
    tick();
    check_all("n1 done", 1'b0, 1'b1, 8'd1, S_DONE);
    start = 1'b1; abort = 1'b1; ncycles = 8'd6;
    tick();
    start = 1'b0; abort = 1'b0; ncycles = '0;
    check_all("start+abort done", 1'b0, 1'b0, 8'd1, S_IDLE);

    // Maximum interval: N = 2^W-1, no wrap
    start_n(8'd255);
    for (int m = 1; m <= 254; m++) begin
      tick();
      if (m == 127 || m == 254) check_all("max count", 1'b1, 1'b0, W'(m), S_COUNT);
    end
    tick();
    check_all("max done", 1'b0, 1'b1, 8'd255, S_DONE);
    tick();
    check_all("max idle", 1'b0, 1'b0, 8'd255, S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_timer.md
CYCLE_TIMER -- requirements
Module: cycle_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the width of the cycle-count load and elapsed-count values.
REQ-002 The block SHALL have port Clk, input, 1, the single system clock; all state SHALL update on its rising edge only.
REQ-003 The block SHALL have port Rst, input, 1, the reset: synchronous and active-high, sampled on the Clk rising edge.
REQ-004 The block SHALL have port Start, input, 1, a request to begin a timed interval of Ncycles clocks.
REQ-005 The block SHALL have port Abort, input, 1, a request to terminate an interval in progress without completion.
REQ-006 The block SHALL have port Ncycles, input, WIDTH, the interval length in clocks, sampled only when Start is accepted.
REQ-007 The block SHALL have port Busy, output, 1, high while an interval is counting.
REQ-008 The block SHALL have port Done, output, 1, a one-cycle pulse marking normal completion of an interval.
REQ-009 The block SHALL have port Pulse_n, output, 1, an active-low pulse equal to the inverse of Busy, usable as a generated reset pulse.
REQ-010 The block SHALL have port Elapsed, output, WIDTH, the number of completed busy cycles of the current or last interval.

Function
REQ-011 The block SHALL implement three states: IDLE, COUNT and DONE.
REQ-012 Start SHALL be accepted only in IDLE or DONE; a Start in COUNT SHALL be ignored, with no restart and no reload.
REQ-013 On Start accepted at edge k with Ncycles=N>0, the state SHALL be COUNT, Busy=1, Pulse_n=0 and Elapsed=0 after edge k, and N SHALL be latched internally.
REQ-014 In COUNT, Elapsed SHALL increment by 1 per edge, giving Elapsed=m after edge k+m.
REQ-015 After edge k+N, the state SHALL be DONE, Busy=0, Pulse_n=1, Done=1 and Elapsed=N; Busy SHALL therefore be high for exactly N cycles.
REQ-016 DONE SHALL last one cycle: the next edge SHALL go to IDLE with Done=0, unless Start is accepted on that edge.
REQ-017 A Start accepted in DONE SHALL behave as in REQ-013, allowing back-to-back intervals with no idle gap.
REQ-018 On Start accepted at edge k with Ncycles=0, the block SHALL enter DONE after edge k with Done=1 and Elapsed=0, and Busy SHALL never assert.
REQ-019 Abort high in COUNT SHALL move the block to IDLE on the next edge with Busy=0 and Pulse_n=1, SHALL not assert Done, and SHALL hold Elapsed at its count at that point.
REQ-020 Abort in IDLE or DONE SHALL have no effect; if Start and Abort are high on the same edge, Abort SHALL take priority and the Start SHALL be discarded.
REQ-021 Elapsed SHALL hold its value in IDLE and DONE until the next accepted Start clears it.
REQ-022 The internal counter SHALL be WIDTH bits and SHALL never wrap; N=2^WIDTH-1 SHALL be supported.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-024 Rst high on an edge SHALL force state IDLE, Busy=0, Done=0, Pulse_n=1 and Elapsed=0, overriding Start and Abort.
REQ-025 Rst asserted mid-COUNT SHALL terminate the interval with no Done pulse; the first Start after Rst falls SHALL operate normally.

Verification
REQ-026 Reset then Start with Ncycles=5 -> Busy high and Pulse_n low for exactly 5 cycles; Elapsed counts 0..5; Done high for 1 cycle on the edge where Busy falls.
REQ-027 Start with Ncycles=0 -> Done pulses the cycle after Start; Busy stays 0; Elapsed=0.
REQ-028 Start with Ncycles=10, Abort after Elapsed=4 -> Busy low on the next edge; no Done; Elapsed holds 4 (or 5 if the counter increments on the Abort edge, which the bench SHALL check against REQ-019 timing); Start with Ncycles=3 in COUNT is ignored.
REQ-029 Start with Ncycles=3, then Start with Ncycles=2 during the DONE cycle -> Busy 3 cycles, Done, then Busy 2 cycles immediately, then Done again.
REQ-030 Start with Ncycles=8, Rst at Elapsed=3 -> all outputs at reset values on the next edge; no Done; Start and Abort on the same edge in IDLE -> nothing happens.
